// File: rtl/timer_pkg.sv
// Shared constants for the N-bit timer/counter core.
// Mode encodings, interrupt-enable bit positions and prescaler width.
package timer_pkg;

    localparam logic [1:0] MODE_FREE    = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    localparam int IE_OVF = 0;
    localparam int IE_UDF = 1;
    localparam int IE_CMP = 2;

    localparam int PC_W = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler; emits a one-cycle tick every 2^(cks+1) clocks.
// The counter is never cleared by a cks change, only by reset.
module tick_prescaler
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cks,
    output logic       tick
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        mask = 4'b0001;
        unique case (cks)
            2'd0: mask = 4'b0001;
            2'd1: mask = 4'b0011;
            2'd2: mask = 4'b0111;
            2'd3: mask = 4'b1111;
            default: mask = 4'b0001;
        endcase
    end

    // tick when every selected low bit of pc is one
    assign tick = &(pc | ~mask);

endmodule

// File: rtl/timer_counter_n.sv
// N-bit up/down timer/counter with prescaler, three count modes,
// sticky overflow/underflow/compare flags and a registered interrupt.
module timer_counter_n
    import timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cks,
    input  logic [1:0]       mode,
    input  logic             up_down,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] start_counter,
    input  logic [WIDTH-1:0] cmp_value,
    input  logic             clr_overflow,
    input  logic             clr_underflow,
    input  logic             clr_cmp,
    input  logic [2:0]       ie,
    output logic [WIDTH-1:0] cnt,
    output logic             overflow,
    output logic             underflow,
    output logic             cmp_match,
    output logic             running,
    output logic             irq
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

    logic             tick;
    logic             step;
    logic             term;
    logic             rld;
    logic [WIDTH-1:0] nxt;
    logic             set_ovf;
    logic             set_udf;
    logic             set_cmp;
    logic             stop;
    logic [2:0]       flags;

    tick_prescaler u_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .cks   (cks),
        .tick  (tick)
    );

    always_comb begin
        rld = 1'b0;
        unique case (mode)
            MODE_RELOAD:  rld = 1'b1;
            MODE_ONESHOT: rld = 1'b1;
            MODE_FREE:    rld = 1'b0;
            default:      rld = 1'b0;
        endcase
    end

    always_comb begin
        step = tick & enable & running & ~load;
        term = up_down ? (cnt == MAXV) : (cnt == '0);
        nxt  = up_down ? (cnt + ONE) : (cnt - ONE);
        // free-run wraps naturally; reload modes restart from start_counter
        if (term && rld) begin
            nxt = start_counter;
        end
        set_ovf = step & term & up_down;
        set_udf = step & term & ~up_down;
        set_cmp = step & (nxt == cmp_value);
        stop    = step & term & (mode == MODE_ONESHOT);
    end

    always_comb begin
        flags         = '0;
        flags[IE_OVF] = overflow;
        flags[IE_UDF] = underflow;
        flags[IE_CMP] = cmp_match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            running   <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            cmp_match <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (load) begin
                cnt     <= start_counter;
                running <= 1'b1;
            end else if (step) begin
                cnt <= nxt;
                if (stop) begin
                    running <= 1'b0;
                end
            end
            // a set in the same cycle as its clear strobe wins
            overflow  <= set_ovf | (overflow  & ~clr_overflow);
            underflow <= set_udf | (underflow & ~clr_underflow);
            cmp_match <= set_cmp | (cmp_match & ~clr_cmp);
            irq       <= |(flags & ie);
        end
    end

endmodule

// File: tb/tb_timer_counter_n.sv
// Bench for timer_counter_n: 8-bit and 12-bit builds run side by side
// against an arithmetic model, plus directed hand-computed checks.
module tb_timer_counter_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  cks = 2'd0;
    logic [1:0]  mode = 2'd0;
    logic        up_down = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  sc = 8'd0;
    logic [7:0]  cmpv = 8'd0;
    logic        clr_ovf = 1'b0;
    logic        clr_udf = 1'b0;
    logic        clr_cmp = 1'b0;
    logic [2:0]  ie = 3'd0;

    logic [7:0]  cnt8;
    logic [11:0] cnt12;
    logic        o8, u8, c8, r8, i8;
    logic        o12, u12, c12, r12, i12;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    timer_counter_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .cks(cks), .mode(mode),
        .up_down(up_down), .enable(enable), .load(load),
        .start_counter(sc), .cmp_value(cmpv),
        .clr_overflow(clr_ovf), .clr_underflow(clr_udf),
        .clr_cmp(clr_cmp), .ie(ie), .cnt(cnt8),
        .overflow(o8), .underflow(u8), .cmp_match(c8),
        .running(r8), .irq(i8)
    );

    timer_counter_n #(.WIDTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .cks(cks), .mode(mode),
        .up_down(up_down), .enable(enable), .load(load),
        .start_counter({4'd0, sc}), .cmp_value({4'd0, cmpv}),
        .clr_overflow(clr_ovf), .clr_underflow(clr_udf),
        .clr_cmp(clr_cmp), .ie(ie), .cnt(cnt12),
        .overflow(o12), .underflow(u12), .cmp_match(c12),
        .running(r12), .irq(i12)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: lane 0 is the 8-bit build, lane 1 the 12-bit build.
    int m_cnt[2];
    bit m_ovf[2], m_udf[2], m_cmp[2], m_run[2], m_irq[2];
    int m_cyc;

    always @(posedge clk or negedge rst_n) begin : model
        int per, c, nx, mx;
        bit tk, so, su, cm, st;
        if (!rst_n) begin
            m_cyc <= 0;
            for (int l = 0; l < 2; l++) begin
                m_cnt[l] <= 0;
                m_ovf[l] <= 0;
                m_udf[l] <= 0;
                m_cmp[l] <= 0;
                m_run[l] <= 1;
                m_irq[l] <= 0;
            end
        end else begin
            per = 2 << cks;
            tk = (m_cyc % per) == (per - 1);
            m_cyc <= m_cyc + 1;
            for (int l = 0; l < 2; l++) begin
                mx = (l == 0) ? 255 : 4095;
                c = m_cnt[l];
                nx = c;
                so = 0;
                su = 0;
                cm = 0;
                st = m_run[l];
                if (load) begin
                    nx = int'(sc);
                    st = 1;
                end else if (tk && enable && m_run[l]) begin
                    if (up_down) begin
                        nx = c + 1;
                        if (nx > mx) begin so = 1; nx = 0; end
                    end else begin
                        nx = c - 1;
                        if (nx < 0) begin su = 1; nx = mx; end
                    end
                    if ((so || su) && (mode == 2'd1 || mode == 2'd2)) nx = int'(sc);
                    if ((so || su) && mode == 2'd2) st = 0;
                    cm = (nx == int'(cmpv));
                end
                m_irq[l] <= (m_cmp[l] && ie[2]) || (m_udf[l] && ie[1]) || (m_ovf[l] && ie[0]);
                m_cnt[l] <= nx;
                m_run[l] <= st;
                m_ovf[l] <= so || (m_ovf[l] && !clr_ovf);
                m_udf[l] <= su || (m_udf[l] && !clr_udf);
                m_cmp[l] <= cm || (m_cmp[l] && !clr_cmp);
            end
        end
    end

    always @(negedge clk) begin
        chk("m_cnt8", int'(cnt8), m_cnt[0]);
        chk("m_ovf8", int'(o8), int'(m_ovf[0]));
        chk("m_udf8", int'(u8), int'(m_udf[0]));
        chk("m_cmp8", int'(c8), int'(m_cmp[0]));
        chk("m_run8", int'(r8), int'(m_run[0]));
        chk("m_irq8", int'(i8), int'(m_irq[0]));
        chk("m_cnt12", int'(cnt12), m_cnt[1]);
        chk("m_ovf12", int'(o12), int'(m_ovf[1]));
        chk("m_udf12", int'(u12), int'(m_udf[1]));
        chk("m_cmp12", int'(c12), int'(m_cmp[1]));
        chk("m_run12", int'(r12), int'(m_run[1]));
        chk("m_irq12", int'(i12), int'(m_irq[1]));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr_all();
        clr_ovf = 1;
        clr_udf = 1;
        clr_cmp = 1;
        cyc(1);
        clr_ovf = 0;
        clr_udf = 0;
        clr_cmp = 0;
    endtask

    initial begin : stim
        int k, chg, prev, lastk, gap;
        #1 rst_n = 0;
        cyc(5);
        rst_n = 1;
        chk("rst_cnt", int'(cnt8), 0);
        chk("rst_run", int'(r8), 1);
        chk("rst_flags", int'({o8, u8, c8}), 0);
        chk("rst_irq", int'(i8), 0);

        // down, free-run, cks=0: load 10
        mode = 2'd0; up_down = 0; cks = 2'd0; sc = 8'd10;
        load = 1; cyc(1); load = 0; enable = 1;
        prev = int'(cnt8); chg = 0; k = 0;
        while (!u8 && k < 200) begin
            cyc(1);
            if (int'(cnt8) != prev) chg++;
            prev = int'(cnt8);
            k++;
        end
        enable = 0;
        chk("udf_set", int'(u8), 1);
        chk("udf_ticks", chg, 11);
        chk("udf_cnt8", int'(cnt8), 255);
        chk("udf_cnt12", int'(cnt12), 4095);
        cyc(1);
        clr_udf = 1; cyc(1); clr_udf = 0;
        chk("udf_clr", int'(u8), 0);

        // set coinciding with a held clear leaves the flag set
        sc = 8'd0; load = 1; cyc(1); load = 0;
        clr_udf = 1; enable = 1; k = 0;
        while (!u8 && k < 40) begin cyc(1); k++; end
        clr_udf = 0; enable = 0;
        chk("set_wins", int'(u8), 1);
        cyc(1);
        clr_all();

        // up, auto-reload, cks=1
        mode = 2'd1; up_down = 1; cks = 2'd1; sc = 8'd250;
        load = 1; cyc(1); load = 0; enable = 1;
        prev = int'(cnt8); chg = 0; k = 0; lastk = 0; gap = 0;
        while (!o8 && k < 200) begin
            cyc(1);
            k++;
            if (int'(cnt8) != prev) begin
                chg++;
                if (chg > 1) gap = k - lastk;
                lastk = k;
            end
            prev = int'(cnt8);
        end
        enable = 0;
        chk("ovf_set", int'(o8), 1);
        chk("ovf_ticks", chg, 6);
        chk("ovf_cnt", int'(cnt8), 250);
        chk("tick_gap", gap, 4);
        cyc(1);
        clr_all();

        // one-shot down from 3
        mode = 2'd2; up_down = 0; sc = 8'd3;
        load = 1; cyc(1); load = 0; enable = 1;
        prev = int'(cnt8); chg = 0; k = 0;
        while (!u8 && k < 200) begin
            cyc(1);
            if (int'(cnt8) != prev) chg++;
            prev = int'(cnt8);
            k++;
        end
        chk("os_udf", int'(u8), 1);
        chk("os_ticks", chg, 4);
        chk("os_cnt", int'(cnt8), 3);
        chk("os_run", int'(r8), 0);
        cyc(20);
        chk("os_hold8", int'(cnt8), 3);
        chk("os_hold12", int'(cnt12), 3);
        load = 1; cyc(1); load = 0;
        chk("os_rerun", int'(r8), 1);
        k = 0;
        while (cnt8 == 8'd3 && k < 20) begin cyc(1); k++; end
        chk("os_resume", int'(cnt8), 2);
        enable = 0;
        cyc(1);
        clr_all();

        // compare + irq
        mode = 2'd0; cks = 2'd0; up_down = 1; sc = 8'd0;
        cmpv = 8'd5; ie = 3'b100;
        load = 1; cyc(1); load = 0; enable = 1;
        prev = int'(cnt8); chg = 0; k = 0;
        while (!c8 && k < 200) begin
            cyc(1);
            if (int'(cnt8) != prev) chg++;
            prev = int'(cnt8);
            k++;
        end
        chk("cmp_set", int'(c8), 1);
        chk("cmp_ticks", chg, 5);
        chk("cmp_cnt", int'(cnt8), 5);
        chk("irq_lag0", int'(i8), 0);
        cyc(1);
        chk("irq_lag1", int'(i8), 1);

        // asynchronous reset in the middle of a count
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_cnt8", int'(cnt8), 0);
        chk("arst_cnt12", int'(cnt12), 0);
        chk("arst_cmp", int'(c8), 0);
        chk("arst_run", int'(r8), 1);
        chk("arst_irq", int'(i8), 0);
        @(negedge clk);
        #1 rst_n = 1;
        enable = 0;

        // loading the compare value directly never sets cmp_match
        sc = 8'd5; load = 1; cyc(1); load = 0;
        cyc(3);
        chk("ld_cnt", int'(cnt8), 5);
        chk("ld_no_cmp", int'(c8), 0);

        // load held across a tick at cnt=0 counting down
        mode = 2'd0; up_down = 0; cks = 2'd0; ie = 3'b111;
        sc = 8'd0; load = 1; cyc(1);
        enable = 1; cyc(2);
        load = 0; enable = 0;
        chk("prio_cnt", int'(cnt8), 0);
        chk("prio_udf", int'(u8), 0);
        chk("prio_udf12", int'(u12), 0);
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_counter_n.md
# timer_counter_n

Parametrised N-bit timer/counter core, the successor to the fixed 8-bit up/down counter in the 8-bit timer block. It has an internal selectable tick prescaler, three count modes (free-run, auto-reload, one-shot), a compare-match flag and a maskable interrupt. It sits between the register bank, which drives its control inputs, and the interrupt controller, which consumes `irq`.

## Interface
- `WIDTH`, default 8: counter, load, reload and compare width (≥2).
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cks` in 2: prescaler select; tick rate = clk/2^(cks+1), i.e. /2, /4, /8 or /16.
- `mode` in 2: 00 free-run, 01 auto-reload, 10 one-shot, 11 treated as free-run.
- `up_down` in 1: 1 = count up, 0 = count down.
- `enable` in 1: count enable.
- `load` in 1: synchronous load of `start_counter` into the count register.
- `start_counter` in WIDTH: load value; also the reload value in auto-reload and one-shot modes.
- `cmp_value` in WIDTH: compare value.
- `clr_overflow`, `clr_underflow`, `clr_cmp` in 1 each: one-cycle clear strobes for the sticky flags.
- `ie` in 3: interrupt enables for {cmp, underflow, overflow}.
- `cnt` out WIDTH: current count register.
- `overflow`, `underflow`, `cmp_match` out 1 each: sticky flags.
- `running` out 1: internal run bit.
- `irq` out 1: registered OR of (flags & `ie`).

## Operation
- **Reset values:** `cnt`=0, all flags 0, `running`=1, `irq`=0, prescaler count 0.
- **Prescaler:** a 4-bit free-running counter `pc` increments every clk. `tick`=1 in the cycle where `pc[cks:0]` is all ones. `cks` changes take effect on the next cycle; `pc` is not reset by the change.
- **Count step:** occurs when `tick & enable & running & ~load`.
  - Up: `cnt+1`. Down: `cnt-1`.
- **Terminal event:** an up step from 2^WIDTH−1 sets `overflow`; a down step from 0 sets `underflow`. The next value depends on mode:
  - Free-run: wrap to 0 (up) or 2^WIDTH−1 (down).
  - Auto-reload: next value = `start_counter`.
  - One-shot: next value = `start_counter`, and `running` clears to 0.
- **Load:** `load`=1 sets `cnt`←`start_counter` and `running`←1, regardless of `tick` or `enable`. Load has priority over a count step in the same cycle. Load never sets any flag.
- **Compare:** `cmp_match` sets when a count step (including a terminal-event reload) produces a next value equal to `cmp_value`. Loads never set it.
- **Flag clear:** a `clr_*` strobe clears its flag. If a set and a clear coincide in the same cycle, set wins.
- **irq:** `irq` ← |({cmp_match, underflow, overflow} & `ie`), registered, so it lags the flags by one cycle.
- **Mode changes:** a `mode` change mid-count takes effect at the next terminal event. Leaving one-shot does not restart a stopped counter; only `load` sets `running`.
- **Mid-operation reset:** `rst_n` low immediately forces all reset values, with no dependence on clk.

## Timing
- Count, flag and `running` updates happen on the same clk edge and are visible one cycle after the tick cycle.
- `irq` is visible two cycles after the tick cycle.
- Load-to-`cnt` latency: 1 clk.
- Flag clear latency: 1 clk.
- With `enable` held high and the counter loaded with L counting down, `underflow` sets on the (L+1)-th qualified tick.
- No handshakes; all strobes are level-sampled each cycle.

## Structure
- The shared package `timer_pkg` holds:
  - mode encodings `MODE_FREE`, `MODE_RELOAD`, `MODE_ONESHOT`;
  - `ie` bit indices `IE_OVF`=0, `IE_UDF`=1, `IE_CMP`=2;
  - the prescaler width constant `PC_W`=4.
- One sub-module, `tick_prescaler`, contains `pc` and the `cks` select and outputs a one-cycle `tick`.
- The core counter, flags, run bit and irq stay in `timer_counter_n`.

## Test plan
- **Reset/idle:** hold `rst_n` low 5 clks, then release → `cnt`=0, all flags 0, `running`=1, `irq`=0. Assert `rst_n` low mid-count → every output returns to its reset value before the next clk edge.
- **Down, free-run, cks=0, WIDTH=8:** load 10, `enable`=1 → `underflow` sets on the 11th tick and `cnt`=255 at the same time. `clr_underflow` → the flag clears 1 clk later. A set coinciding with a clear leaves the flag 1.
- **Up, auto-reload:** load 250, `start_counter`=250, cks=1 → after 6 ticks, `overflow`=1 and `cnt`=250. Ticks arrive every 4 clks.
- **One-shot down:** load 3 → after 4 ticks, `underflow`=1, `cnt`=3, `running`=0, and further ticks leave `cnt` at 3. `load` → `running`=1 and counting resumes.
- **Compare + irq:** load 0, up, `cmp_value`=5, `ie`=3'b100 → `cmp_match` sets on the 5th tick and `irq` rises 1 clk later. Loading 5 directly leaves `cmp_match` 0.
- **Priority:** `load` asserted in a tick cycle with `cnt`=0 counting down → `cnt`=`start_counter` and no `underflow`. A WIDTH=12 build repeats the down/free-run case with wrap to 4095.
